// File: rtl/alu_flags_unit_if.sv
// Control, flag and condition-evaluation signals between the sequencer and alu_flags_unit.
// MainBus is tri-stated, so it stays a plain inout on the unit rather than living here.
interface alu_flags_unit_if #(
    parameter int FLAG_W = 5
);
    logic              Flags_0_Overflow;
    logic              Flags_1_Sign;
    logic              Flags_2_Zero;
    logic              Flags_3_CarryA;
    logic              Flags_4_CarryL;
    logic              FlagsLoad;
    logic              FlagsLoadBus;
    logic              FlagsAssert;
    logic              IntSave;
    logic              IntRestore;
    logic              CondEval;
    logic [3:0]        CondSel;
    logic              CondValid;
    logic              CondTaken;
    logic              LCarryIn;
    logic [FLAG_W-1:0] FlagsOut;
    logic              Collision;

    modport master (
        output Flags_0_Overflow, Flags_1_Sign, Flags_2_Zero, Flags_3_CarryA, Flags_4_CarryL,
        output FlagsLoad, FlagsLoadBus, FlagsAssert, IntSave, IntRestore, CondEval, CondSel,
        input  CondValid, CondTaken, LCarryIn, FlagsOut, Collision
    );

    modport slave (
        input  Flags_0_Overflow, Flags_1_Sign, Flags_2_Zero, Flags_3_CarryA, Flags_4_CarryL,
        input  FlagsLoad, FlagsLoadBus, FlagsAssert, IntSave, IntRestore, CondEval, CondSel,
        output CondValid, CondTaken, LCarryIn, FlagsOut, Collision
    );
endinterface

// File: rtl/alu_flags_unit.sv
// Architectural flags register with shadow copy, MainBus transfer and registered branch conditions.
// Optional macro ALU_FLAGS_BYPASS_EN forwards live ALU flags into condition evaluation and LCarryIn.
module alu_flags_unit #(
    parameter int                 BUS_W       = 8,
    parameter int                 FLAG_W      = 5,
    parameter logic [FLAG_W-1:0]  RESET_FLAGS = '0
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    alu_flags_unit_if.slave       fif,
    inout  wire  [BUS_W-1:0]      MainBus
);
    localparam int F_O  = 0;
    localparam int F_S  = 1;
    localparam int F_Z  = 2;
    localparam int F_CA = 3;
    localparam int F_CL = 4;

    logic [FLAG_W-1:0] flags;
    logic [FLAG_W-1:0] shadow;
    logic [FLAG_W-1:0] alu_flags;
    logic [FLAG_W-1:0] cond_flags;
    logic              bus_load_ok;
    logic              collision_now;
    logic              cond_result;
    logic              unused_bus_bits;

    assign alu_flags = {fif.Flags_4_CarryL, fif.Flags_3_CarryA, fif.Flags_2_Zero,
                        fif.Flags_1_Sign, fif.Flags_0_Overflow};

    // While asserting, the bus carries our own flags; loading them back would be a no-op loop.
    assign bus_load_ok   = fif.FlagsLoadBus & ~fif.FlagsAssert;
    assign collision_now = (fif.FlagsAssert & fif.FlagsLoadBus) | (fif.FlagsLoadBus & fif.FlagsLoad);

    assign MainBus = fif.FlagsAssert ? {{(BUS_W-FLAG_W){1'b0}}, flags} : {BUS_W{1'bz}};
    assign unused_bus_bits = ^MainBus[BUS_W-1:FLAG_W];

`ifdef ALU_FLAGS_BYPASS_EN
    assign cond_flags = (fif.FlagsLoad & ~fif.IntRestore & ~fif.FlagsLoadBus) ? alu_flags : flags;
    assign fif.LCarryIn = fif.FlagsLoad ? fif.Flags_4_CarryL : flags[F_CL];
`else
    assign cond_flags   = flags;
    assign fif.LCarryIn = flags[F_CL];
`endif

    assign fif.FlagsOut = flags;

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        cond_result = 1'b0;
        case (fif.CondSel)
            4'd0:  cond_result = 1'b1;
            4'd1:  cond_result = 1'b0;
            4'd2:  cond_result =  cond_flags[F_O];
            4'd3:  cond_result = ~cond_flags[F_O];
            4'd4:  cond_result =  cond_flags[F_S];
            4'd5:  cond_result = ~cond_flags[F_S];
            4'd6:  cond_result =  cond_flags[F_Z];
            4'd7:  cond_result = ~cond_flags[F_Z];
            4'd8:  cond_result =  cond_flags[F_CA];
            4'd9:  cond_result = ~cond_flags[F_CA];
            4'd10: cond_result =  cond_flags[F_CL];
            4'd11: cond_result = ~cond_flags[F_CL];
            4'd12: cond_result =  cond_flags[F_CA] & ~cond_flags[F_Z];
            4'd13: cond_result = ~cond_flags[F_CA] |  cond_flags[F_Z];
            4'd14: cond_result =  (cond_flags[F_S] == cond_flags[F_O]);
            4'd15: cond_result =  (cond_flags[F_S] != cond_flags[F_O]);
            default: cond_result = 1'b0;
        endcase
    end

    // NOTE: non-blocking assignments let IntSave and IntRestore in one edge swap flags and shadow.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            flags         <= RESET_FLAGS;
            shadow        <= '0;
            fif.CondValid <= 1'b0;
            fif.CondTaken <= 1'b0;
            fif.Collision <= 1'b0;
        end else begin
            if (fif.IntRestore)     flags <= shadow;
            else if (bus_load_ok)   flags <= MainBus[FLAG_W-1:0];
            else if (fif.FlagsLoad) flags <= alu_flags;

            if (fif.IntSave) shadow <= flags;

            fif.CondValid <= fif.CondEval;
            if (fif.CondEval) fif.CondTaken <= cond_result;

            fif.Collision <= collision_now;
        end
    end
endmodule

// File: tb/tb_alu_flags_unit.sv
// Directed bench for alu_flags_unit: flag loads, shadow save/restore, bus transfer, collisions and conditions.
module tb_alu_flags_unit;
    logic       Clock;
    logic       Reset_n;
    logic       tb_bus_en;
    logic [7:0] tb_bus_val;
    wire  [7:0] MainBus;

    int total = 0;
    int bad   = 0;
    logic       exp_q[$];
    logic [4:0] model;

    alu_flags_unit_if #(.FLAG_W(5)) ifc ();

    alu_flags_unit #(.BUS_W(8), .FLAG_W(5), .RESET_FLAGS(5'b00000)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .fif     (ifc.slave),
        .MainBus (MainBus)
    );

    assign MainBus = tb_bus_en ? tb_bus_val : 8'hzz;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic cond_model(input logic [3:0] sel, input logic [4:0] f);
        logic o, s, z, ca, cl;
        {cl, ca, z, s, o} = f;
        case (sel)
            4'd0:  return 1'b1;
            4'd1:  return 1'b0;
            4'd2:  return o;
            4'd3:  return !o;
            4'd4:  return s;
            4'd5:  return !s;
            4'd6:  return z;
            4'd7:  return !z;
            4'd8:  return ca;
            4'd9:  return !ca;
            4'd10: return cl;
            4'd11: return !cl;
            4'd12: return ca && !z;
            4'd13: return !ca || z;
            4'd14: return s == o;
            default: return s != o;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_alu(input logic [4:0] f);
        {ifc.Flags_4_CarryL, ifc.Flags_3_CarryA, ifc.Flags_2_Zero,
         ifc.Flags_1_Sign, ifc.Flags_0_Overflow} = f;
    endtask

    // One clock; every evaluation requested before the edge must surface as a result after it.
    task automatic tick();
        logic ev;
        ev = ifc.CondEval;
        @(posedge Clock);
        #1;
        check("cond_valid", ifc.CondValid, ev);
        if (ev) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL scoreboard_empty observed=result expected=none");
            end else begin
                check("cond_taken", ifc.CondTaken, exp_q.pop_front());
            end
        end
    endtask

    task automatic eval(input logic [3:0] sel);
        ifc.CondEval = 1'b1;
        ifc.CondSel  = sel;
        exp_q.push_back(cond_model(sel, model));
    endtask

    task automatic load_alu(input logic [4:0] f);
        set_alu(f);
        ifc.FlagsLoad = 1'b1;
        tick();
        ifc.FlagsLoad = 1'b0;
        model = f;
        check("alu_load", ifc.FlagsOut, f);
    endtask

    initial begin
        logic [4:0] pats [3];
        pats = '{5'b01001, 5'b10110, 5'b00101};

        Reset_n = 1'b0;
        tb_bus_en = 1'b0;
        tb_bus_val = 8'h00;
        set_alu(5'b11111);
        ifc.FlagsLoad = 0; ifc.FlagsLoadBus = 0; ifc.FlagsAssert = 0;
        ifc.IntSave = 0; ifc.IntRestore = 0; ifc.CondEval = 0; ifc.CondSel = 4'd0;
        model = 5'b00000;
        #12;
        check("rst_flags", ifc.FlagsOut, 5'b00000);
        check("rst_lcarry", ifc.LCarryIn, 1'b0);
        check("rst_valid", ifc.CondValid, 1'b0);
        check("rst_taken", ifc.CondTaken, 1'b0);
        check("rst_collision", ifc.Collision, 1'b0);
        Reset_n = 1'b1;
        tick();
        check("post_rst_flags", ifc.FlagsOut, 5'b00000);

        // ALU load, carry loop and bus drive/release
        load_alu(5'b10100);
        check("lcarry_after_load", ifc.LCarryIn, 1'b1);
        tb_bus_en = 1'b1; tb_bus_val = 8'h0A;
        #1 check("bus_released", MainBus, 8'h0A);
        tb_bus_en = 1'b0; ifc.FlagsAssert = 1'b1;
        #1 check("bus_driven", MainBus, 8'h14);
        ifc.FlagsAssert = 1'b0;

        // Back-to-back evaluations, then hold on idle
        load_alu(5'b00110);
        eval(4'd6);  tick();
        eval(4'd7);  tick();
        eval(4'd12); tick();
        eval(4'd14); tick();
        eval(4'd0);  tick();
        ifc.CondEval = 1'b0;
        tick();
        check("taken_hold", ifc.CondTaken, 1'b1);

        foreach (pats[p]) begin
            load_alu(pats[p]);
            for (int s = 0; s < 16; s++) begin
                eval(4'(s));
                tick();
            end
            ifc.CondEval = 1'b0;
        end

        // Shadow save, bus load, restore, swap
        load_alu(5'b01001);
        ifc.IntSave = 1'b1; tick(); ifc.IntSave = 1'b0;
        check("save_keeps_flags", ifc.FlagsOut, 5'b01001);
        tb_bus_en = 1'b1; tb_bus_val = 8'h04; ifc.FlagsLoadBus = 1'b1;
        tick();
        tb_bus_en = 1'b0; ifc.FlagsLoadBus = 1'b0;
        check("bus_load", ifc.FlagsOut, 5'b00100);
        ifc.IntRestore = 1'b1; tick(); ifc.IntRestore = 1'b0;
        check("restore", ifc.FlagsOut, 5'b01001);
        load_alu(5'b10010);
        ifc.IntSave = 1'b1; ifc.IntRestore = 1'b1; tick();
        ifc.IntSave = 1'b0;
        check("swap_flags", ifc.FlagsOut, 5'b01001);
        tick(); ifc.IntRestore = 1'b0;
        check("swap_shadow", ifc.FlagsOut, 5'b10010);

        // Collisions
        ifc.FlagsAssert = 1'b1; ifc.FlagsLoadBus = 1'b1;
        tick();
        ifc.FlagsAssert = 1'b0; ifc.FlagsLoadBus = 1'b0;
        check("assert_loadbus_flags", ifc.FlagsOut, 5'b10010);
        check("collision_pulse1", ifc.Collision, 1'b1);
        tick();
        check("collision_clear1", ifc.Collision, 1'b0);
        set_alu(5'b00001);
        ifc.FlagsAssert = 1'b1; ifc.FlagsLoadBus = 1'b1; ifc.FlagsLoad = 1'b1;
        tick();
        ifc.FlagsAssert = 1'b0; ifc.FlagsLoadBus = 1'b0; ifc.FlagsLoad = 1'b0;
        check("suppressed_bus_alu_wins", ifc.FlagsOut, 5'b00001);
        check("collision_pulse2", ifc.Collision, 1'b1);
        set_alu(5'b00100);
        tb_bus_en = 1'b1; tb_bus_val = 8'h02;
        ifc.FlagsLoadBus = 1'b1; ifc.FlagsLoad = 1'b1;
        tick();
        tb_bus_en = 1'b0; ifc.FlagsLoadBus = 1'b0; ifc.FlagsLoad = 1'b0;
        check("bus_beats_alu", ifc.FlagsOut, 5'b00010);
        check("collision_pulse3", ifc.Collision, 1'b1);
        tick();
        check("collision_clear3", ifc.Collision, 1'b0);

        // Compare-then-branch in one cycle
        load_alu(5'b00000);
        set_alu(5'b00100);
        ifc.FlagsLoad = 1'b1; ifc.CondEval = 1'b1; ifc.CondSel = 4'd6;
`ifdef ALU_FLAGS_BYPASS_EN
        exp_q.push_back(1'b1);
`else
        exp_q.push_back(1'b0);
`endif
        tick();
        ifc.FlagsLoad = 1'b0; ifc.CondEval = 1'b0;
        model = 5'b00100;
        set_alu(5'b10000);
        ifc.FlagsLoad = 1'b1;
        #1;
`ifdef ALU_FLAGS_BYPASS_EN
        check("lcarry_forward", ifc.LCarryIn, 1'b1);
`else
        check("lcarry_forward", ifc.LCarryIn, 1'b0);
`endif
        tick();
        ifc.FlagsLoad = 1'b0;
        model = 5'b10000;

        // Reset while a result is showing
        eval(4'd0); tick();
        ifc.CondEval = 1'b0;
        #1 Reset_n = 1'b0;
        #1;
        check("midrst_valid", ifc.CondValid, 1'b0);
        check("midrst_taken", ifc.CondTaken, 1'b0);
        check("midrst_flags", ifc.FlagsOut, 5'b00000);
        Reset_n = 1'b1;
        model = 5'b00000;
        tick();
        load_alu(5'b11111);
        ifc.IntRestore = 1'b1; tick(); ifc.IntRestore = 1'b0;
        check("shadow_reset", ifc.FlagsOut, 5'b00000);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
